// File: rtl/pipeline_redirect_ctrl_if.sv
// pipeline_redirect_ctrl_if: bundle between CP0/IF/pipeline and the redirect controller
//   inputs to the controller : cp0_flush, cp0_return_pc, fetch_busy, inst_data_ok,
//                              stallreq_if, stallreq_id, stallreq_mem
//   outputs of the controller: stall, flush, new_pc, new_pc_valid, discard_fetch, drain_timeout
interface pipeline_redirect_ctrl_if;
  logic        cp0_flush;
  logic [31:0] cp0_return_pc;
  logic        fetch_busy;
  logic        inst_data_ok;
  logic        stallreq_if;
  logic        stallreq_id;
  logic        stallreq_mem;
  logic [5:0]  stall;
  logic        flush;
  logic [31:0] new_pc;
  logic        new_pc_valid;
  logic        discard_fetch;
  logic        drain_timeout;
  modport master (
    output cp0_flush, cp0_return_pc, fetch_busy, inst_data_ok,
           stallreq_if, stallreq_id, stallreq_mem,
    input  stall, flush, new_pc, new_pc_valid, discard_fetch, drain_timeout
  );
  modport slave (
    input  cp0_flush, cp0_return_pc, fetch_busy, inst_data_ok,
           stallreq_if, stallreq_id, stallreq_mem,
    output stall, flush, new_pc, new_pc_valid, discard_fetch, drain_timeout
  );
endinterface

// File: rtl/pipeline_redirect_ctrl.sv
// pipeline_redirect_ctrl: turns CP0 flush pulses into a pipeline flush and one clean PC redirect,
// draining any in-flight instruction fetch first, and arbitrates stage stall requests.
//   clk, rst (sync, active-low) ; bus : pipeline_redirect_ctrl_if.slave
module pipeline_redirect_ctrl #(
  parameter logic [31:0]          RESET_PC    = 32'hbfc0_0000,
  parameter int                   TIMEOUT_W   = 8,
  parameter logic [TIMEOUT_W-1:0] TIMEOUT_MAX = TIMEOUT_W'(200)
) (
  input logic                     clk,
  input logic                     rst,
  pipeline_redirect_ctrl_if.slave bus
);
  typedef enum logic [1:0] {IDLE, DRAIN, REDIRECT} state_t;
  state_t               state;
  logic                 flush, new_pc_valid, discard_fetch, drain_timeout;
  logic [31:0]          new_pc;
  logic [TIMEOUT_W-1:0] cnt, cnt_nx;
  logic [5:0]           stall;
  assign cnt_nx = (cnt == TIMEOUT_MAX) ? cnt : cnt + 1'b1;
  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= IDLE;
      flush         <= 1'b0;
      new_pc_valid  <= 1'b0;
      discard_fetch <= 1'b0;
      drain_timeout <= 1'b0;
      new_pc        <= RESET_PC;
      cnt           <= '0;
    end else begin
      flush <= bus.cp0_flush;
      if (bus.cp0_flush) new_pc <= bus.cp0_return_pc;
      cnt <= (state == DRAIN) ? cnt_nx : '0;
      if (state == DRAIN && cnt_nx == TIMEOUT_MAX) drain_timeout <= 1'b1;
      case (state)
        DRAIN: begin
          // a flush landing here only retargets new_pc; the pending response still has to drain
          state         <= bus.inst_data_ok ? REDIRECT : DRAIN;
          new_pc_valid  <= bus.inst_data_ok;
          discard_fetch <= !bus.inst_data_ok;
        end
        default: begin
          // IDLE and REDIRECT react identically to a new flush
          state         <= (bus.cp0_flush && bus.fetch_busy) ? DRAIN : IDLE;
          new_pc_valid  <= bus.cp0_flush && !bus.fetch_busy;
          discard_fetch <= bus.cp0_flush && bus.fetch_busy;
        end
      endcase
    end
  end
  always_comb
    stall = !rst                          ? 6'b000000 :
            (flush || state == REDIRECT)  ? 6'b000000 :
            (state == DRAIN)              ? 6'b000011 :
            bus.stallreq_mem              ? 6'b011111 :
            bus.stallreq_id               ? 6'b000111 :
            bus.stallreq_if               ? 6'b000011 : 6'b000000;
  assign bus.stall         = stall;
  assign bus.flush         = flush;
  assign bus.new_pc        = new_pc;
  assign bus.new_pc_valid  = new_pc_valid;
  assign bus.discard_fetch = discard_fetch;
  assign bus.drain_timeout = drain_timeout;
endmodule
